// File: rtl/iscsqrt_param.sv
// In-stream unipolar stochastic square root: a correlated divider whose divisor is fed back from the output.
// Optional windowed ones counter on out is built when ISCSQRT_CNT_EN is defined.
module iscsqrt_param #(
    parameter int                 DEPTH   = 2,
    parameter int                 SELW    = $clog2(DEPTH),
    parameter logic [DEPTH-1:0]   INIT_SR = {DEPTH/2{2'b10}},
    parameter int                 WARMUP  = 16,
    parameter int                 CNTW    = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [SELW-1:0] sel,
    input  logic            in,
    output logic            out,
    output logic            out_vld,
    output logic [CNTW:0]   cnt_val,
    output logic            cnt_done
);

    localparam logic [7:0] WARM = 8'(WARMUP);

    logic             r_tog;
    logic [DEPTH-1:0] r_sr;
    logic [7:0]       r_wcnt;
    logic             w_sr_bit;
    logic             w_out;
    logic             w_div;

    // Output mux: a selected zero passes a 1, a selected one passes the input; forced high in reset.
    always_comb begin
        w_sr_bit = r_sr[sel];
        w_out    = 1'b1;
        if (rst) begin
            w_out = 1'b1;
        end else if (w_sr_bit) begin
            w_out = in;
        end else begin
            w_out = 1'b1;
        end
        w_div = r_tog | w_out;
    end

    assign out     = w_out;
    assign out_vld = (r_wcnt == WARM) & ~rst;

    // Toggle dividend, divider shift register and saturating warm-up counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tog  <= 1'b0;
            r_sr   <= INIT_SR;
            r_wcnt <= 8'd0;
        end else if (en) begin
            r_tog <= ~r_tog;
            if (w_div) begin
                r_sr <= {r_sr[DEPTH-2:0], r_tog};
            end else begin
                r_sr <= r_sr;
            end
            if (r_wcnt != WARM) begin
                r_wcnt <= r_wcnt + 8'd1;
            end else begin
                r_wcnt <= r_wcnt;
            end
        end else begin
            r_tog  <= r_tog;
            r_sr   <= r_sr;
            r_wcnt <= r_wcnt;
        end
    end

`ifdef ISCSQRT_CNT_EN
    logic [CNTW-1:0] r_win;
    logic [CNTW:0]   r_acc;
    logic [CNTW:0]   r_cnt_val;
    logic            r_cnt_done;
    logic [CNTW:0]   w_add;

    assign w_add = {{CNTW{1'b0}}, w_out};

    // Window counter: the last valid cycle of a window folds its own out bit into the published total.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_win      <= '0;
            r_acc      <= '0;
            r_cnt_val  <= '0;
            r_cnt_done <= 1'b0;
        end else begin
            r_cnt_done <= 1'b0;
            if (en && out_vld) begin
                r_win <= r_win + CNTW'(1);
                if (r_win == {CNTW{1'b1}}) begin
                    r_cnt_val  <= r_acc + w_add;
                    r_cnt_done <= 1'b1;
                    r_acc      <= '0;
                end else begin
                    r_acc <= r_acc + w_add;
                end
            end else begin
                r_win <= r_win;
                r_acc <= r_acc;
            end
        end
    end

    assign cnt_val  = r_cnt_val;
    assign cnt_done = r_cnt_done;
`else
    assign cnt_val  = '0;
    assign cnt_done = 1'b0;
`endif

endmodule
